// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode encodings, machine word and memory-stage FSM states.
// Helper functions classify opcodes for the memory-access stage.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [5:0] {
      RTYPE = 6'b000000,
      ADDI  = 6'b001000,
      LW    = 6'b100011,
      SW    = 6'b101011,
      LL    = 6'b110000,
      SC    = 6'b111000
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      HOLD
   } memstate_t;

   function automatic logic is_memop(opcode_t op);
      return op inside {LW, SW, LL, SC};
   endfunction

   function automatic logic is_read(opcode_t op);
      return op inside {LW, LL};
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache request port between the memory-access stage (master) and the cache (slave).
// Addresses and data are one machine word wide.
interface mem_access_unit_if;
   import cpu_types_pkg::*;

   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;
   logic  dhit;
   word_t dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );

endinterface

// File: rtl/ll_sc_link.sv
// LL/SC link register: remembers the word address of the last LL and drops it on
// an explicit clear or a matching coherence snoop. Address bits below LINK_CMP_LSB are ignored.
module ll_sc_link #(
   parameter int ADDR_W       = 32,
   parameter int LINK_CMP_LSB = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              set_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] cmp_addr_i,
   input  logic              snoop_inv_i,
   input  logic [ADDR_W-1:0] snoop_addr_i,
   output logic              link_valid_o,
   output logic              match_o
);

   localparam int TAG_W = ADDR_W - LINK_CMP_LSB;

   logic             link_valid_q;
   logic [TAG_W-1:0] link_tag_q;
   logic             snoop_hit;
   logic [LINK_CMP_LSB-1:0] unused_low_bits;

   assign unused_low_bits = set_addr_i[LINK_CMP_LSB-1:0] ^ cmp_addr_i[LINK_CMP_LSB-1:0]
                          ^ snoop_addr_i[LINK_CMP_LSB-1:0];

   assign snoop_hit = link_valid_q & snoop_inv_i
                    & (snoop_addr_i[ADDR_W-1:LINK_CMP_LSB] == link_tag_q);

   // A snoop landing in the same cycle counts as already invalidated, so an SC sees it.
   assign match_o = link_valid_q & ~snoop_hit
                  & (cmp_addr_i[ADDR_W-1:LINK_CMP_LSB] == link_tag_q);

   assign link_valid_o = link_valid_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         link_valid_q <= 1'b0;
         link_tag_q   <= '0;
      end else if (set_i) begin
         link_valid_q <= 1'b1;
         link_tag_q   <= set_addr_i[ADDR_W-1:LINK_CMP_LSB];
      end else if (clr_i || snoop_hit) begin
         link_valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage controller: issues LW/SW/LL/SC to the data cache, stalls the
// pipeline until dhit, captures load data and the SC result, and owns the LL/SC link.
module mem_access_unit
   import cpu_types_pkg::*;
#(
   parameter int ADDR_W       = 32,  // must equal the width of word_t
   parameter int DATA_W       = 32,  // must equal the width of word_t
   parameter int LINK_CMP_LSB = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ex_valid,
   input  logic              flush,
   input  opcode_t           op,
   input  logic [ADDR_W-1:0] ex_alu_out,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              snoop_inv,
   input  logic [ADDR_W-1:0] snoop_addr,
   mem_access_unit_if.master dbus,
   output logic              mem_stall,
   output logic [DATA_W-1:0] mem_dmemload,
   output logic [DATA_W-1:0] mem_sc_result,
   output logic              mem_done
);

   memstate_t         state_q;
   opcode_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] load_q;
   logic              ren_q;
   logic              wen_q;
   logic              done_q;
   logic              sc_q;

   logic              go;
   logic              in_idle;
   logic              in_access;
   logic              acc_hit;
   logic              sc_fail;
   logic              link_set;
   logic              link_clr;
   logic              link_match;
   logic              link_valid;
   logic [ADDR_W-1:0] cmp_addr;

   assign go        = ex_valid & ~flush & is_memop(op);
   assign in_idle   = (state_q == IDLE);
   assign in_access = (state_q == ACCESS);
   assign acc_hit   = in_access & dbus.dhit;

   // The link is checked against the incoming SC in IDLE and the latched address in ACCESS.
   assign cmp_addr  = in_access ? addr_q : ex_alu_out;
   assign sc_fail   = (op == SC) & ~link_match;

   assign link_set  = acc_hit & (op_q == LL);
   assign link_clr  = (acc_hit & ((op_q == SC) | ((op_q == SW) & link_match)))
                    | (in_idle & go & sc_fail);

   ll_sc_link #(
      .ADDR_W       (ADDR_W),
      .LINK_CMP_LSB (LINK_CMP_LSB)
   ) u_link (
      .CLK          (CLK),
      .RST          (RST),
      .set_i        (link_set),
      .set_addr_i   (addr_q),
      .clr_i        (link_clr),
      .cmp_addr_i   (cmp_addr),
      .snoop_inv_i  (snoop_inv),
      .snoop_addr_i (snoop_addr),
      .link_valid_o (link_valid),
      .match_o      (link_match)
   );

   // NOTE: mem_stall must react in the detect cycle, so it is a continuous assign from
   // state and inputs rather than a register; a complete expression cannot infer a latch.
   assign mem_stall     = (in_idle & go) | in_access;
   assign mem_done      = done_q;
   assign mem_dmemload  = load_q;
   assign mem_sc_result = {{(DATA_W-1){1'b0}}, sc_q};

   assign dbus.dmemREN   = ren_q;
   assign dbus.dmemWEN   = wen_q;
   assign dbus.dmemaddr  = addr_q;
   assign dbus.dmemstore = data_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         op_q    <= RTYPE;
         addr_q  <= '0;
         data_q  <= '0;
         load_q  <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         done_q  <= 1'b0;
         sc_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults at the top are overridden below; done_q is thus a
         // one-cycle pulse raised only on the transitions into HOLD.
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (go) begin
                  if (sc_fail) begin
                     sc_q    <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= HOLD;
                  end else begin
                     op_q    <= op;
                     addr_q  <= ex_alu_out;
                     data_q  <= ex_store_data;
                     ren_q   <= is_read(op);
                     wen_q   <= ~is_read(op);
                     state_q <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // The bus transaction is never abandoned; flush has no effect here.
               if (dbus.dhit) begin
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= HOLD;
                  if (is_read(op_q)) begin
                     load_q <= dbus.dmemload;
                  end
                  if (op_q == SC) begin
                     sc_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: cycle-by-cycle vector table plus hand-written
// sequences for reset during an access and a variable-latency cache response.
module tb_mem_access_unit;
   import cpu_types_pkg::*;

   typedef struct {
      logic    rst;
      logic    v;
      logic    fl;
      opcode_t op;
      word_t   a;
      word_t   sd;
      logic    dh;
      word_t   dl;
      logic    sn;
      word_t   sa;
      logic    ren;
      logic    wen;
      logic    stall;
      logic    done;
      word_t   eaddr;
      word_t   estore;
      word_t   eload;
      word_t   esc;
   } vec_t;

   localparam word_t D = 32'hDEAD_BEEF;

   logic    CLK;
   logic    RST;
   logic    ex_valid;
   logic    flush;
   opcode_t op;
   word_t   ex_alu_out;
   word_t   ex_store_data;
   logic    snoop_inv;
   word_t   snoop_addr;
   logic    mem_stall;
   word_t   mem_dmemload;
   word_t   mem_sc_result;
   logic    mem_done;

   int total = 0;
   int bad   = 0;

   mem_access_unit_if dbus ();

   mem_access_unit dut (
      .CLK           (CLK),
      .RST           (RST),
      .ex_valid      (ex_valid),
      .flush         (flush),
      .op            (op),
      .ex_alu_out    (ex_alu_out),
      .ex_store_data (ex_store_data),
      .snoop_inv     (snoop_inv),
      .snoop_addr    (snoop_addr),
      .dbus          (dbus),
      .mem_stall     (mem_stall),
      .mem_dmemload  (mem_dmemload),
      .mem_sc_result (mem_sc_result),
      .mem_done      (mem_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input word_t act, input word_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      RST           = t.rst;
      ex_valid      = t.v;
      flush         = t.fl;
      op            = t.op;
      ex_alu_out    = t.a;
      ex_store_data = t.sd;
      dbus.dhit     = t.dh;
      dbus.dmemload = t.dl;
      snoop_inv     = t.sn;
      snoop_addr    = t.sa;
   endtask

   function automatic vec_t stim(logic rst, logic v, opcode_t o, word_t a, word_t sd, logic dh, word_t dl);
      vec_t t;
      t = '{rst, v, 1'b0, o, a, sd, dh, dl, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
      return t;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic compare(input string tag, input vec_t t);
      check({tag, " ren"},   32'(dbus.dmemREN), 32'(t.ren));
      check({tag, " wen"},   32'(dbus.dmemWEN), 32'(t.wen));
      check({tag, " stall"}, 32'(mem_stall),    32'(t.stall));
      check({tag, " done"},  32'(mem_done),     32'(t.done));
      check({tag, " load"},  mem_dmemload,      t.eload);
      check({tag, " sc"},    mem_sc_result,     t.esc);
      if (t.ren || t.wen) begin
         check({tag, " addr"},  dbus.dmemaddr,  t.eaddr);
         check({tag, " store"}, dbus.dmemstore, t.estore);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      int   delay;
      int   ren_cnt;
      logic done_seen;

      // Fields: rst v fl op a sd dh dl sn sa | ren wen stall done eaddr estore eload esc
      tbl.push_back('{0,0,0,RTYPE,0,0,0,0,0,0,         0,0,0,0,0,0,0,0});
      tbl.push_back('{0,1,0,LW,'h40,0,0,0,0,0,         0,0,1,0,0,0,0,0});
      tbl.push_back('{0,1,0,LW,'h40,0,0,0,0,0,         1,0,1,0,'h40,0,0,0});
      tbl.push_back('{0,1,0,LW,'h40,0,1,D,0,0,         1,0,1,0,'h40,0,0,0});
      tbl.push_back('{0,1,0,LW,'h40,0,0,0,0,0,         0,0,0,1,0,0,D,0});
      tbl.push_back('{0,0,0,RTYPE,0,0,0,0,0,0,         0,0,0,0,0,0,D,0});
      tbl.push_back('{0,1,0,SW,'h80,'h1234,0,0,0,0,    0,0,1,0,0,0,D,0});
      tbl.push_back('{0,1,0,SW,'h80,'h1234,1,0,0,0,    0,1,1,0,'h80,'h1234,D,0});
      tbl.push_back('{0,1,0,SW,'h80,'h1234,0,0,0,0,    0,0,0,1,0,0,D,0});
      tbl.push_back('{0,1,1,LW,'h40,0,0,0,0,0,         0,0,0,0,0,0,D,0});
      tbl.push_back('{0,1,0,RTYPE,'h40,0,0,0,0,0,      0,0,0,0,0,0,D,0});
      tbl.push_back('{0,1,1,SC,'h100,5,0,0,0,0,        0,0,0,0,0,0,D,0});
      tbl.push_back('{0,1,0,LL,'h100,0,0,0,0,0,        0,0,1,0,0,0,D,0});
      tbl.push_back('{0,1,0,LL,'h100,0,1,'h77,0,0,     1,0,1,0,'h100,0,D,0});
      tbl.push_back('{0,1,0,LL,'h100,0,0,0,0,0,        0,0,0,1,0,0,'h77,0});
      tbl.push_back('{0,1,0,SC,'h100,5,0,0,0,0,        0,0,1,0,0,0,'h77,0});
      tbl.push_back('{0,1,0,SC,'h100,5,1,0,0,0,        0,1,1,0,'h100,5,'h77,0});
      tbl.push_back('{0,1,0,SC,'h100,5,0,0,0,0,        0,0,0,1,0,0,'h77,1});
      tbl.push_back('{0,1,0,SC,'h100,6,0,0,0,0,        0,0,1,0,0,0,'h77,1});
      tbl.push_back('{0,1,0,SC,'h100,6,0,0,0,0,        0,0,0,1,0,0,'h77,0});
      tbl.push_back('{0,1,0,LL,'h100,0,0,0,0,0,        0,0,1,0,0,0,'h77,0});
      tbl.push_back('{0,1,0,LL,'h100,0,1,'hAA,0,0,     1,0,1,0,'h100,0,'h77,0});
      tbl.push_back('{0,1,0,LL,'h100,0,0,0,0,0,        0,0,0,1,0,0,'hAA,0});
      tbl.push_back('{0,0,0,RTYPE,0,0,0,0,1,'h102,     0,0,0,0,0,0,'hAA,0});
      tbl.push_back('{0,1,0,SC,'h100,5,0,0,0,0,        0,0,1,0,0,0,'hAA,0});
      tbl.push_back('{0,1,0,SC,'h100,5,0,0,0,0,        0,0,0,1,0,0,'hAA,0});
      tbl.push_back('{0,1,0,LL,'h200,0,0,0,0,0,        0,0,1,0,0,0,'hAA,0});
      tbl.push_back('{0,1,0,LL,'h200,0,1,'h10,0,0,     1,0,1,0,'h200,0,'hAA,0});
      tbl.push_back('{0,1,0,LL,'h200,0,0,0,0,0,        0,0,0,1,0,0,'h10,0});
      tbl.push_back('{0,1,0,LL,'h200,0,0,0,0,0,        0,0,1,0,0,0,'h10,0});
      tbl.push_back('{0,1,0,LL,'h200,0,1,'h11,1,'h200, 1,0,1,0,'h200,0,'h10,0});
      tbl.push_back('{0,1,0,LL,'h200,0,0,0,1,'h204,    0,0,0,1,0,0,'h11,0});
      tbl.push_back('{0,1,0,SC,'h200,9,0,0,0,0,        0,0,1,0,0,0,'h11,0});
      tbl.push_back('{0,1,0,SC,'h200,9,1,0,0,0,        0,1,1,0,'h200,9,'h11,0});
      tbl.push_back('{0,1,0,SC,'h200,9,0,0,0,0,        0,0,0,1,0,0,'h11,1});
      tbl.push_back('{0,1,0,LL,'h300,0,0,0,0,0,        0,0,1,0,0,0,'h11,1});
      tbl.push_back('{0,1,0,LL,'h300,0,1,'h22,0,0,     1,0,1,0,'h300,0,'h11,1});
      tbl.push_back('{0,1,0,LL,'h300,0,0,0,0,0,        0,0,0,1,0,0,'h22,1});
      tbl.push_back('{0,1,0,SC,'h300,1,0,0,1,'h300,    0,0,1,0,0,0,'h22,1});
      tbl.push_back('{0,1,0,SC,'h300,1,0,0,0,0,        0,0,0,1,0,0,'h22,0});
      tbl.push_back('{0,1,0,LL,'h400,0,0,0,0,0,        0,0,1,0,0,0,'h22,0});
      tbl.push_back('{0,1,0,LL,'h400,0,1,'h33,0,0,     1,0,1,0,'h400,0,'h22,0});
      tbl.push_back('{0,1,0,LL,'h400,0,0,0,0,0,        0,0,0,1,0,0,'h33,0});
      tbl.push_back('{0,1,0,SW,'h400,'hABCD,0,0,0,0,   0,0,1,0,0,0,'h33,0});
      tbl.push_back('{0,1,0,SW,'h400,'hABCD,1,0,0,0,   0,1,1,0,'h400,'hABCD,'h33,0});
      tbl.push_back('{0,1,0,SW,'h400,'hABCD,0,0,0,0,   0,0,0,1,0,0,'h33,0});
      tbl.push_back('{0,1,0,SC,'h400,2,0,0,0,0,        0,0,1,0,0,0,'h33,0});
      tbl.push_back('{0,1,0,SC,'h400,2,0,0,0,0,        0,0,0,1,0,0,'h33,0});

      // Reset state.
      drive(stim(1'b1, 1'b0, RTYPE, 0, 0, 1'b0, 0));
      repeat (2) @(posedge CLK);
      #1;
      drive(stim(1'b0, 1'b0, RTYPE, 0, 0, 1'b0, 0));
      #2;
      check("reset ren",   32'(dbus.dmemREN), 32'h0);
      check("reset wen",   32'(dbus.dmemWEN), 32'h0);
      check("reset stall", 32'(mem_stall),    32'h0);
      check("reset done",  32'(mem_done),     32'h0);
      check("reset load",  mem_dmemload,      32'h0);
      check("reset sc",    mem_sc_result,     32'h0);
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i]);
         #2;
         compare($sformatf("r%0d", i), tbl[i]);
         tick();
      end

      // Reset mid-ACCESS: requests hold until the edge, then everything clears, link included.
      drive(stim(1'b0, 1'b1, LL, 32'h500, 0, 1'b0, 0));
      #2; check("rst ll detect stall", 32'(mem_stall), 32'h1);
      tick();
      drive(stim(1'b0, 1'b1, LL, 32'h500, 0, 1'b1, 32'h55));
      #2; check("rst ll ren", 32'(dbus.dmemREN), 32'h1);
      tick();
      drive(stim(1'b0, 1'b1, LL, 32'h500, 0, 1'b0, 0));
      #2; check("rst ll done", 32'(mem_done), 32'h1);
      check("rst ll load", mem_dmemload, 32'h55);
      tick();
      drive(stim(1'b0, 1'b1, LW, 32'h600, 0, 1'b0, 0));
      #2; check("rst lw detect stall", 32'(mem_stall), 32'h1);
      tick();
      drive(stim(1'b1, 1'b1, LW, 32'h600, 0, 1'b0, 0));
      #2; check("rst during access ren", 32'(dbus.dmemREN), 32'h1);
      tick();
      drive(stim(1'b0, 1'b0, RTYPE, 0, 0, 1'b0, 0));
      #2;
      check("post rst ren",   32'(dbus.dmemREN), 32'h0);
      check("post rst wen",   32'(dbus.dmemWEN), 32'h0);
      check("post rst stall", 32'(mem_stall),    32'h0);
      check("post rst done",  32'(mem_done),     32'h0);
      check("post rst load",  mem_dmemload,      32'h0);
      tick();
      drive(stim(1'b0, 1'b1, SC, 32'h500, 32'h7, 1'b0, 0));
      #2; check("post rst sc stall", 32'(mem_stall), 32'h1);
      tick();
      #2;
      check("post rst sc wen",   32'(dbus.dmemWEN), 32'h0);
      check("post rst sc done",  32'(mem_done),     32'h1);
      check("post rst sc stall", 32'(mem_stall),    32'h0);
      check("post rst sc res",   mem_sc_result,     32'h0);
      tick();

      // Variable-latency load: dhit arrives on the delay-th request cycle.
      delay = int'($urandom_range(2, 5));
      drive(stim(1'b0, 1'b1, LW, 32'h7C, 0, 1'b0, 0));
      #2; check("lat detect stall", 32'(mem_stall), 32'h1);
      tick();
      ren_cnt   = 0;
      done_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (dbus.dmemREN) begin
            ren_cnt++;
            dbus.dhit     = (ren_cnt == delay);
            dbus.dmemload = 32'hC0DE_0000 | word_t'(delay);
         end else begin
            dbus.dhit = 1'b0;
         end
         #2;
         if (mem_done) begin
            done_seen = 1'b1;
            break;
         end
         tick();
      end
      check("lat done seen",  32'(done_seen),   32'h1);
      check("lat ren cycles", ren_cnt,          delay);
      check("lat hold stall", 32'(mem_stall),   32'h0);
      check("lat load",       mem_dmemload,     32'hC0DE_0000 | word_t'(delay));
      tick();
      drive(stim(1'b0, 1'b0, RTYPE, 0, 0, 1'b0, 0));
      #2; check("lat idle done", 32'(mem_done), 32'h0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access stage controller between the EX/MEM latch and the MEM/WB latch.
- Drives the data-cache request port for LW/SW/LL/SC and holds the pipeline until dhit.
- Captures the load data and produces the SC result word.
- Keeps the LL/SC link register, which own stores and coherence snoops invalidate.

Parameters:
- ADDR_W, 32, address width; must equal word_t width.
- DATA_W, 32, data width; must equal word_t width.
- LINK_CMP_LSB, 2, lowest address bit used in link compares (word granularity).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX/MEM latch holds a live instruction
- flush  in  1  squash the current EX/MEM instruction before issue
- op  in  6  opcode_t of the EX/MEM instruction
- ex_alu_out  in  ADDR_W  effective address from the ALU
- ex_store_data  in  DATA_W  rt value for SW/SC
- dhit  in  1  cache completes the current request
- dmemload  in  DATA_W  cache read data, valid with dhit
- snoop_inv  in  1  coherence invalidate from the other core
- snoop_addr  in  ADDR_W  invalidated address
- dmemREN  out  1  cache read request
- dmemWEN  out  1  cache write request
- dmemaddr  out  ADDR_W  request address
- dmemstore  out  DATA_W  store data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_dmemload  out  DATA_W  to MEM/WB mem_dmemload
- mem_sc_result  out  DATA_W  to MEM/WB mem_ex_out when op==SC
- mem_done  out  1  one-cycle pulse: memory op retires

Behaviour:
- Memory op = LW (100011), SW (101011), LL (110000), SC (111000). go = ex_valid & ~flush & memop.
- Reset values:
  - state=IDLE, link_valid=0, link_addr=0, load_q=0, sc_q=0.
  - All outputs 0.
- FSM states:
  - IDLE
    - If go and the op is not a failing SC: mem_stall=1 combinationally, next state ACCESS; latch addr, store data and op.
    - Failing SC (link_valid=0 or link address mismatch): sc_q=0, no request, next state HOLD.
    - Otherwise: stay in IDLE, mem_stall=0.
  - ACCESS
    - dmemREN=1 (LW/LL) or dmemWEN=1 (SW/SC) from registered op; dmemaddr and dmemstore come from the latched values.
    - mem_stall=1.
    - On dhit: load_q<=dmemload (LW/LL); sc_q<=1 (SC); next state HOLD.
    - Without dhit: stay; requests held stable.
  - HOLD
    - mem_stall=0 and mem_done=1 for this cycle, so the latches advance at this edge.
    - No request is issued. op is ignored, so the same instruction is never issued twice. Next state IDLE.
- Link register:
  - LL dhit: link_valid<=1, link_addr<=addr.
  - SW/SC dhit with a matching address: link_valid<=0.
  - SC completion always clears link_valid.
  - snoop_inv with snoop_addr matching link_addr (bits ADDR_W-1:LINK_CMP_LSB): link_valid<=0 in any state.
- Simultaneous events:
  - A snoop match in the same IDLE cycle as an SC evaluation fails the SC (sc_q=0).
  - A snoop match in the same cycle as an LL dhit: the LL set wins.
  - Once an SC is in ACCESS it succeeds on dhit; coherence is owned by the cache.
- Flush:
  - flush only gates issue in IDLE.
  - An access already in ACCESS always completes; the bus transaction is never abandoned.
- Outputs to MEM/WB:
  - mem_dmemload=load_q and mem_sc_result={31'b0,sc_q}; both hold until the next completion.
- Latency: a minimum of 3 cycles per memory op (IDLE detect, ACCESS with immediate dhit, HOLD). Non-memory ops add 0 cycles.
- RST asserted mid-ACCESS: synchronous return to reset values next edge; requests drop immediately after that edge.

Decomposition:
- Shared package cpu_types_pkg:
  - opcode_t and the LW/SW/LL/SC encodings.
  - word_t.
  - New typedef memstate_t enum {IDLE, ACCESS, HOLD}.
- One sub-module, ll_sc_link: the link register plus its compare and invalidate logic (set, clear, snoop inputs; link_valid, match outputs).

Test Plan:
- LW addr 0x0000_0040, dhit after 2 cycles with data 0xDEAD_BEEF -> dmemREN high for 2 cycles; mem_stall high for 3 cycles; mem_done pulses; mem_dmemload=0xDEAD_BEEF.
- SW addr 0x80, data 0x1234, dhit immediate -> dmemWEN=1, dmemstore=0x1234 for exactly 1 cycle; no dmemREN; single mem_done.
- LL 0x100 then SC 0x100 data 5 -> SC issues dmemWEN; mem_sc_result=1; link_valid=0 afterward.
- LL 0x100, snoop_inv 0x100, then SC 0x100 -> no dmemWEN; mem_sc_result=0; stall for 1 cycle then HOLD.
- flush with LW in IDLE -> no request, mem_stall=0. RST asserted during ACCESS -> REN/WEN=0 and state IDLE next cycle; link cleared.
- ADD op with ex_valid=1 -> mem_stall never asserts; no requests; no mem_done.
